pc_redirect_arbiter: RTL and testbench

Parametrised, registered successor to the branch/jump merge logic, sitting between the EX/MEM redirect sources and the fetch-stage PC mux. It accepts NUM_SRC fixed-priority redirect requests and holds the winning target until fetch accepts it through a valid/ready handshake. After acceptance it asserts a pipeline flush for FLUSH_CYCLES cycles and counts requests it had to drop.

---
 rtl/pc_redirect_arbiter.sv | 147 ++++++++++++++
 tb/tb_pc_redirect_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_arbiter.sv
// pc_redirect_arbiter
// Registered fixed-priority merge of NUM_SRC redirect requests into the fetch
// PC mux. The winning target is held under a valid/ready handshake. An accept
// starts a FLUSH_CYCLES-long flush window. Requests that cannot be taken are
// counted in a saturating 8-bit counter.
module pc_redirect_arbiter #(
   parameter  int NUM_SRC      = 2,
   parameter  int ADDR_W       = 32,
   parameter  int FLUSH_CYCLES = 2,
   localparam int SRC_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC-1:0]        req,
   input  logic [NUM_SRC*ADDR_W-1:0] req_addr,
   input  logic                      fetch_ready,
   output logic                      pcsrc,
   output logic [ADDR_W-1:0]         addr_out,
   output logic [SRC_W-1:0]          redirect_src,
   output logic                      flush,
   output logic [7:0]                drop_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HOLD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES);

   state_t            state;
   logic [3:0]        fl_cnt;

   logic              any_req;
   logic [SRC_W-1:0]  win_idx;
   logic [ADDR_W-1:0] win_addr;
   logic              take;
   logic              drop;

   // Fixed-priority pick: the lowest requesting index wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first; otherwise a path
      // that skips the assignment would infer a latch.
      any_req  = |req;
      win_idx  = '0;
      win_addr = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_idx  = SRC_W'(i);
            win_addr = req_addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Decide whether this cycle's winner is taken (capture/replace) or dropped.
   // The last flush cycle behaves like IDLE, so a request sampled on the edge
   // where flush falls is captured and redirects are FLUSH_CYCLES+1 apart.
   always_comb begin
      take = 1'b0;
      unique case (state)
         IDLE:    take = any_req;
         HOLD:    take = any_req &&
                         ((fetch_ready && FLUSH_CYCLES == 0) ||
                          (!fetch_ready && (win_idx < redirect_src)));
         FLUSH:   take = any_req && (fl_cnt <= 4'd1);
         default: take = 1'b0;
      endcase
      drop = any_req && !take;
   end

   // Redirect FSM with registered outputs and the saturating drop counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state        <= IDLE;
         pcsrc        <= 1'b0;
         addr_out     <= '0;
         redirect_src <= '0;
         flush        <= 1'b0;
         fl_cnt       <= '0;
         drop_cnt     <= '0;
      end else begin
         if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
         end

         unique case (state)
            IDLE: begin
               if (take) begin
                  state        <= HOLD;
                  pcsrc        <= 1'b1;
                  addr_out     <= win_addr;
                  redirect_src <= win_idx;
               end
            end

            HOLD: begin
               if (take) begin
                  // Back-to-back capture or higher-priority replace.
                  addr_out     <= win_addr;
                  redirect_src <= win_idx;
               end else if (fetch_ready) begin
                  pcsrc        <= 1'b0;
                  addr_out     <= '0;
                  redirect_src <= '0;
                  if (FLUSH_CYCLES > 0) begin
                     state  <= FLUSH;
                     flush  <= 1'b1;
                     fl_cnt <= FL_INIT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            FLUSH: begin
               if (fl_cnt <= 4'd1) begin
                  flush  <= 1'b0;
                  fl_cnt <= '0;
                  if (take) begin
                     state        <= HOLD;
                     pcsrc        <= 1'b1;
                     addr_out     <= win_addr;
                     redirect_src <= win_idx;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  fl_cnt <= fl_cnt - 4'd1;
               end
            end

            default: begin
               state        <= IDLE;
               pcsrc        <= 1'b0;
               addr_out     <= '0;
               redirect_src <= '0;
               flush        <= 1'b0;
               fl_cnt       <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_redirect_arbiter.sv
// Bench for pc_redirect_arbiter: three instances (FLUSH_CYCLES = 2, 3, 0)
// share one set of inputs and are compared every cycle against a behavioural
// model, with directed scenarios followed by random traffic.
module tb_pc_redirect_arbiter;

   localparam int NI = 3;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [63:0] req_addr;
   logic        fetch_ready;

   logic        pcsrc_o [NI];
   logic [31:0] addr_o  [NI];
   logic        src_o   [NI];
   logic        flush_o [NI];
   logic [7:0]  drop_o  [NI];

   int total = 0;
   int bad   = 0;

   int fc_of [NI] = '{2, 3, 0};

   typedef struct {
      bit          busy;
      logic [31:0] addr;
      int          src;
      int          fl_left;
      int          drops;
   } mdl_t;

   mdl_t m [NI];

   pc_redirect_arbiter #(.NUM_SRC(2), .ADDR_W(32), .FLUSH_CYCLES(2)) u_fc2 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
      .fetch_ready(fetch_ready), .pcsrc(pcsrc_o[0]), .addr_out(addr_o[0]),
      .redirect_src(src_o[0]), .flush(flush_o[0]), .drop_cnt(drop_o[0]));

   pc_redirect_arbiter #(.NUM_SRC(2), .ADDR_W(32), .FLUSH_CYCLES(3)) u_fc3 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
      .fetch_ready(fetch_ready), .pcsrc(pcsrc_o[1]), .addr_out(addr_o[1]),
      .redirect_src(src_o[1]), .flush(flush_o[1]), .drop_cnt(drop_o[1]));

   pc_redirect_arbiter #(.NUM_SRC(2), .ADDR_W(32), .FLUSH_CYCLES(0)) u_fc0 (
      .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr),
      .fetch_ready(fetch_ready), .pcsrc(pcsrc_o[2]), .addr_out(addr_o[2]),
      .redirect_src(src_o[2]), .flush(flush_o[2]), .drop_cnt(drop_o[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m[k].busy    = 1'b0;
         m[k].addr    = '0;
         m[k].src     = 0;
         m[k].fl_left = 0;
         m[k].drops   = 0;
      end
   endtask

   // Apply the redirect rules to the inputs seen at the edge just taken.
   task automatic model_step();
      for (int k = 0; k < NI; k++) begin
         int          w;
         bit          any;
         bit          tk;
         logic [31:0] wa;
         w   = 2;
         for (int i = 1; i >= 0; i--) if (req[i]) w = i;
         any = (req != 2'b00);
         wa  = (w == 1) ? req_addr[63:32] : req_addr[31:0];
         tk  = 1'b0;
         if (m[k].fl_left > 0) begin
            if (m[k].fl_left == 1) begin
               m[k].fl_left = 0;
               tk = any;
            end else begin
               m[k].fl_left--;
            end
         end else if (!m[k].busy) begin
            tk = any;
         end else if (fetch_ready) begin
            m[k].busy = 1'b0;
            if (fc_of[k] > 0) m[k].fl_left = fc_of[k];
            else tk = any;
         end else begin
            tk = any && (w < m[k].src);
         end
         if (tk) begin
            m[k].busy = 1'b1;
            m[k].addr = wa;
            m[k].src  = w;
         end else if (any && m[k].drops < 255) begin
            m[k].drops++;
         end
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s.pcsrc[%0d]", tag, k), 32'(pcsrc_o[k]), 32'(m[k].busy));
         check($sformatf("%s.addr[%0d]", tag, k), addr_o[k], m[k].busy ? m[k].addr : 32'h0);
         check($sformatf("%s.src[%0d]", tag, k), 32'(src_o[k]), m[k].busy ? 32'(m[k].src) : 32'h0);
         check($sformatf("%s.flush[%0d]", tag, k), 32'(flush_o[k]), 32'(m[k].fl_left > 0));
         check($sformatf("%s.drop[%0d]", tag, k), 32'(drop_o[k]), 32'(m[k].drops));
      end
   endtask

   // One clock: edge, model update, sample 1 time unit after the edge.
   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset pulse placed between edges.
   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all("rst");
      #2 rst_n = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      req         = 2'b00;
      req_addr    = '0;
      fetch_ready = 1'b0;
      model_reset();
      #3 check_all("init");
      #4 rst_n = 1'b1;

      // Async reset mid-HOLD with addr_out = 0x40.
      req = 2'b01; req_addr = {32'h0, 32'h40};
      cycle("hold40");
      check("hold40.addr", addr_o[0], 32'h40);
      req = 2'b00;
      cycle("hold40b");
      pulse_reset();

      // Priority with fetch_ready high.
      fetch_ready = 1'b1;
      req = 2'b11; req_addr = {32'h200, 32'h100};
      cycle("prio");
      check("prio.addr", addr_o[0], 32'h100);
      check("prio.src", 32'(src_o[0]), 32'h0);
      req = 2'b00;
      cycle("prio.f1");
      check("prio.flush1", 32'(flush_o[0]), 32'h1);
      cycle("prio.f2");
      check("prio.flush2", 32'(flush_o[0]), 32'h1);
      cycle("prio.f3");
      check("prio.flush_end", 32'(flush_o[0]), 32'h0);
      check("prio.drop", 32'(drop_o[0]), 32'h0);
      repeat (2) cycle("prio.idle");
      pulse_reset();

      // Stall, repeated low-priority request, then higher-priority replace.
      fetch_ready = 1'b0;
      req = 2'b10; req_addr = {32'h200, 32'h0};
      repeat (3) cycle("stall");
      check("stall.addr", addr_o[0], 32'h200);
      check("stall.drop", 32'(drop_o[0]), 32'h2);
      req = 2'b01; req_addr = {32'h0, 32'h300};
      cycle("replace");
      check("replace.addr", addr_o[0], 32'h300);
      check("replace.src", 32'(src_o[0]), 32'h0);
      req = 2'b00; fetch_ready = 1'b1;
      repeat (5) cycle("replace.drain");
      pulse_reset();

      // Flush window with FLUSH_CYCLES=3: accept-cycle and first two flush
      // cycles drop, request on the closing edge is captured.
      fetch_ready = 1'b1;
      req = 2'b01; req_addr = {32'h0, 32'h40};
      cycle("fw.cap");
      for (int i = 0; i < 4; i++) begin
         req_addr = {32'h0, 32'h44 + 32'(4*i)};
         cycle("fw.req");
         if (i < 3) check("fw.nocap", 32'(pcsrc_o[1]), 32'h0);
      end
      check("fw.drop", 32'(drop_o[1]), 32'h3);
      check("fw.recap", 32'(pcsrc_o[1]), 32'h1);
      req = 2'b00;
      repeat (5) cycle("fw.drain");
      pulse_reset();

      // Back-to-back redirects with FLUSH_CYCLES=0.
      fetch_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req = 2'b01; req_addr = {32'h0, 32'h10 + 32'(4*i)};
         cycle("b2b");
         check("b2b.pcsrc", 32'(pcsrc_o[2]), 32'h1);
         check("b2b.addr", addr_o[2], 32'h10 + 32'(4*i));
         check("b2b.flush", 32'(flush_o[2]), 32'h0);
      end
      req = 2'b00;
      repeat (5) cycle("b2b.drain");
      pulse_reset();

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         req         = 2'($urandom_range(0, 3));
         req_addr    = {32'($urandom), 32'($urandom)};
         fetch_ready = ($urandom_range(0, 3) != 0);
         cycle("rand");
      end
      req = 2'b00; fetch_ready = 1'b1;
      repeat (6) cycle("rand.drain");
      pulse_reset();

      // Drop counter saturation.
      fetch_ready = 1'b0;
      req = 2'b10; req_addr = {32'h500, 32'h0};
      repeat (300) cycle("sat");
      for (int k = 0; k < NI; k++)
         check($sformatf("sat.drop_final[%0d]", k), 32'(drop_o[k]), 32'd255);
      check("sat.src", 32'(src_o[0]), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
